// File: rtl/integrator.sv
// Semi-implicit Euler integrator: walks every object after the city finishes accelerations,
// updates local velocity/position RAMs and is the sole master of the city position write port.
module integrator #(
    parameter int unsigned max_size         = 4096,
    parameter int unsigned m10k_address_len = 12,
    parameter int unsigned accel_lat        = 2,
    parameter int unsigned dt_shift         = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_city_done,
    input  logic [m10k_address_len-1:0] i_num_objects,
    input  logic [m10k_address_len-1:0] i_hps_addr,
    input  logic                        i_hps_we,
    input  logic [31:0]                 i_hps_x,
    input  logic [31:0]                 i_hps_y,
    input  logic [31:0]                 i_hps_mass,
    input  logic [31:0]                 i_hps_vx,
    input  logic [31:0]                 i_hps_vy,
    output logic [m10k_address_len-1:0] o_accel_addr,
    input  logic [31:0]                 i_x_accel,
    input  logic [31:0]                 i_y_accel,
    output logic [m10k_address_len-1:0] o_pos_write_addr,
    output logic                        o_pos_we,
    output logic [31:0]                 o_x_pos,
    output logic [31:0]                 o_y_pos,
    output logic [31:0]                 o_mass,
    output logic                        o_busy,
    output logic                        o_step_done,
    output logic [15:0]                 o_step_count,
    output logic                        o_hps_drop
);

    localparam int unsigned CntW = m10k_address_len + 1;
    localparam int unsigned LatW = (accel_lat > 1) ? $clog2(accel_lat) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(max_size);

    typedef enum logic [2:0] {StIdle, StAddr, StWait, StVel, StPos, StWrite, StDone} state_e;

    state_e                      state_q, state_d;
    logic [m10k_address_len-1:0] idx_q, idx_d;
    logic [CntW-1:0]             count_q, count_d;
    logic [LatW-1:0]             lat_q, lat_d;
    logic                        done_q;
    logic [31:0]                 ax_q, ax_d, ay_q, ay_d;
    logic [31:0]                 vx_q, vx_d, vy_q, vy_d;
    logic [31:0]                 px_q, px_d, py_q, py_d;
    logic [15:0]                 step_cnt_q, step_cnt_d;

    logic [31:0] px_mem [max_size];
    logic [31:0] py_mem [max_size];
    logic [31:0] vx_mem [max_size];
    logic [31:0] vy_mem [max_size];
    logic [31:0] mass_mem [max_size];
    logic [31:0] rd_px_q, rd_py_q, rd_vx_q, rd_vy_q, rd_mass_q;

    logic                        mem_we, mass_we, mem_addr_ok;
    logic [m10k_address_len-1:0] mem_addr;
    logic [31:0]                 mem_px, mem_py, mem_vx, mem_vy;
    logic                        city_rise;
    logic [CntW-1:0]             count_in;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) begin
            sat_add = s[32] ? 32'h8000_0000 : 32'h7fff_ffff;
        end else begin
            sat_add = s[31:0];
        end
    endfunction

    function automatic logic [31:0] scale_dt(input logic [31:0] v);
        scale_dt = $signed(v) >>> dt_shift;
    endfunction

    assign city_rise = i_city_done & ~done_q;

    always_comb begin
        count_in = {1'b0, i_num_objects};
        if (count_in > MaxCnt) begin
            count_in = MaxCnt;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        lat_d      = lat_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        px_d       = px_q;
        py_d       = py_q;
        step_cnt_d = step_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (city_rise) begin
                    count_d = count_in;
                    idx_d   = '0;
                    state_d = (count_in == '0) ? StDone : StAddr;
                end
            end
            StAddr: begin
                lat_d   = LatW'(accel_lat - 1);
                state_d = StWait;
            end
            StWait: begin
                if (lat_q == '0) begin
                    ax_d    = i_x_accel;
                    ay_d    = i_y_accel;
                    state_d = StVel;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StVel: begin
                vx_d    = sat_add(rd_vx_q, scale_dt(ax_q));
                vy_d    = sat_add(rd_vy_q, scale_dt(ay_q));
                state_d = StPos;
            end
            StPos: begin
                px_d    = sat_add(rd_px_q, scale_dt(vx_q));
                py_d    = sat_add(rd_py_q, scale_dt(vy_q));
                state_d = StWrite;
            end
            StWrite: begin
                if ({1'b0, idx_q} == count_q - CntW'(1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StAddr;
                end
            end
            StDone: begin
                step_cnt_d = step_cnt_q + 16'd1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            count_q    <= '0;
            lat_q      <= '0;
            done_q     <= 1'b0;
            ax_q       <= '0;
            ay_q       <= '0;
            vx_q       <= '0;
            vy_q       <= '0;
            px_q       <= '0;
            py_q       <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            lat_q      <= lat_d;
            done_q     <= i_city_done;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            px_q       <= px_d;
            py_q       <= py_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Single local write port: HPS loads while idle, integration results in WRITE.
    always_comb begin
        mem_we   = 1'b0;
        mass_we  = 1'b0;
        mem_addr = idx_q;
        mem_px   = px_q;
        mem_py   = py_q;
        mem_vx   = vx_q;
        mem_vy   = vy_q;
        if (state_q == StIdle && i_hps_we) begin
            mem_we   = 1'b1;
            mass_we  = 1'b1;
            mem_addr = i_hps_addr;
            mem_px   = i_hps_x;
            mem_py   = i_hps_y;
            mem_vx   = i_hps_vx;
            mem_vy   = i_hps_vy;
        end else if (state_q == StWrite) begin
            mem_we = 1'b1;
        end
    end

    assign mem_addr_ok = ({1'b0, mem_addr} < MaxCnt);

    always_ff @(posedge i_clk) begin
        if (mem_we && mem_addr_ok) begin
            px_mem[mem_addr] <= mem_px;
            py_mem[mem_addr] <= mem_py;
            vx_mem[mem_addr] <= mem_vx;
            vy_mem[mem_addr] <= mem_vy;
        end
        if (mass_we && mem_addr_ok) begin
            mass_mem[mem_addr] <= i_hps_mass;
        end
        if (state_q == StAddr) begin
            rd_px_q   <= px_mem[idx_q];
            rd_py_q   <= py_mem[idx_q];
            rd_vx_q   <= vx_mem[idx_q];
            rd_vy_q   <= vy_mem[idx_q];
            rd_mass_q <= mass_mem[idx_q];
        end
    end

    always_comb begin
        o_pos_we         = 1'b0;
        o_pos_write_addr = '0;
        o_x_pos          = '0;
        o_y_pos          = '0;
        o_mass           = '0;
        if (state_q == StIdle) begin
            o_pos_we         = i_hps_we;
            o_pos_write_addr = i_hps_addr;
            o_x_pos          = i_hps_x;
            o_y_pos          = i_hps_y;
            o_mass           = i_hps_mass;
        end else if (state_q == StWrite) begin
            o_pos_we         = 1'b1;
            o_pos_write_addr = idx_q;
            o_x_pos          = px_q;
            o_y_pos          = py_q;
            o_mass           = rd_mass_q;
        end
    end

    assign o_accel_addr = idx_q;
    assign o_busy       = (state_q != StIdle);
    assign o_step_done  = (state_q == StDone);
    assign o_step_count = step_cnt_q;
    assign o_hps_drop   = i_hps_we & o_busy;

endmodule

// File: doc/integrator.md
# integrator

Downstream stage of the city force engine. Once the city signals that all accelerations are computed, this block walks every object in order. For each object it reads the x/y acceleration from the city, updates a locally held velocity and position with a semi-implicit Euler step, and writes the new position and the unchanged mass back into the city's position write port. Between steps it forwards HPS load writes to the city and keeps its own shadow copy of them, so it is the only master on the city write port.

## Interface
Parameters:
- max_size, 4096, object capacity; depth of the local position, velocity and mass RAMs
- m10k_address_len, 12, object index width
- accel_lat, 2, cycles from driving o_accel_addr to valid i_x_accel/i_y_accel
- dt_shift, 4, time step as a power of two: dt = 2^-dt_shift

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  reset, asynchronous, active-low
- i_city_done  in  1  city acceleration-complete level
- i_num_objects  in  m10k_address_len  object count; sampled at step start
- i_hps_addr  in  m10k_address_len  HPS load index
- i_hps_we  in  1  HPS load strobe
- i_hps_x, i_hps_y, i_hps_mass  in  32 each  initial position and mass
- i_hps_vx, i_hps_vy  in  32 each  initial velocity
- o_accel_addr  out  m10k_address_len  acceleration read index to the city
- i_x_accel, i_y_accel  in  32 each  acceleration from the city
- o_pos_write_addr  out  m10k_address_len  city write index
- o_pos_we  out  1  city write strobe
- o_x_pos, o_y_pos, o_mass  out  32 each  city write data
- o_busy  out  1  step in progress
- o_step_done  out  1  one-cycle pulse at step completion
- o_step_count  out  16  completed steps; wraps 0xFFFF->0
- o_hps_drop  out  1  one-cycle pulse when an HPS write is rejected

## Operation
- Number format: positions, velocities and accelerations are signed Q16.16. Mass passes through untouched.
- States: IDLE, ADDR, WAIT, VEL, POS, WRITE, DONE.
- IDLE:
  - The city write port is combinationally driven from the HPS inputs.
  - Each HPS write is also stored into the local RAMs at i_hps_addr.
  - A rising edge of i_city_done (registered edge detect) latches i_num_objects and sets idx=0.
    - Latched count 0: go to DONE, no writes.
    - Otherwise: go to ADDR.
- ADDR: drive o_accel_addr=idx and issue the local RAM read for idx.
- WAIT: hold for accel_lat cycles, counting down. At exit, capture i_x_accel and i_y_accel.
- VEL: v' = sat32(v + (a >>> dt_shift)), per axis, arithmetic shift.
- POS: p' = sat32(p + (v' >>> dt_shift)), per axis.
- sat32: clamp to 0x7FFFFFFF / 0x80000000 on signed overflow.
- WRITE:
  - Assert o_pos_we for one cycle with o_pos_write_addr=idx, o_x_pos/o_y_pos=p', o_mass=stored mass.
  - Write v' and p' to the local RAMs.
  - If idx == count-1, go to DONE. Otherwise idx++ and go to ADDR.
- DONE: pulse o_step_done, increment o_step_count, return to IDLE.
- A new step needs i_city_done to fall and rise again. A level held high does not retrigger.
- HPS write while o_busy: it is not forwarded, not stored, and o_hps_drop pulses.
- i_city_done rising edge while busy: ignored.
- i_num_objects > max_size: clamped to max_size.

## Timing
- Reset values:
  - State IDLE, idx 0.
  - All outputs 0, except the combinational HPS pass-through in IDLE.
  - o_step_count 0.
  - Local RAM contents are not reset.
- Start latency: ADDR is entered one cycle after the registered i_city_done edge.
- Per object: accel_lat+4 cycles (6 at default). N objects take N*(accel_lat+4)+1 cycles including DONE.
- o_busy is high from ADDR entry through the DONE cycle inclusive.
- o_pos_we is asserted only in WRITE or on an HPS pass-through, never in the same cycle as both.
- o_accel_addr holds idx through ADDR and WAIT.
- Reset asserted mid-step: immediate return to IDLE, no further writes, o_step_count 0. A partially updated RAM state is accepted.

## Test plan
- Single object (dt_shift=4):
  - Stimulus: HPS load p=(0x00010000,0), v=0; accel=(0x00100000,0); raise i_city_done.
  - Required: v'=0x00010000, one write of x=0x00011000, y=0, mass unchanged; o_step_done 6 cycles after ADDR entry; o_step_count=1.
- Saturation:
  - Stimulus: p.x=0x7FFFF000, v.x=0x7FFFFFF0, a.x=0x7FFFFFFF.
  - Required: v'.x=0x7FFFFFFF, written x=0x7FFFFFFF. Mirrored negative case gives 0x80000000.
- Three objects, accel_lat=3:
  - Required: writes at indices 0,1,2 exactly 7 cycles apart; o_step_done 1 cycle after the third write. Second step uses the updated velocities.
- Zero objects:
  - Stimulus: count=0, rising edge of i_city_done.
  - Required: no o_pos_we, o_step_done 1 cycle after the edge.
- HPS write at cycle 3 of a step:
  - Required: o_hps_drop pulses; city write data unaffected; local RAM unchanged.
- Reset low mid-WAIT:
  - Required: o_busy=0 and o_pos_we=0 next cycle. After release, HPS pass-through works, and a new i_city_done edge restarts at idx 0.
